s1_syn_calc: RTL

- Syndrome calculator, the stage directly upstream of the 2-error KES stage in the RS decoder over GF(2^8).
- Consumes one received codeword as a byte stream, highest-degree coefficient first.
- Computes S_i = R(alpha^(FCR+i)) for i = 0..3 by Horner recursion.
- Presents the four syndromes as registered outputs with a one-cycle kes_ena-compatible done pulse.

---
 rtl/s1_syn_calc.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/s1_syn_calc.sv
// Reed-Solomon syndrome calculator over GF(2^8): Horner-evaluates S0..S3 of a byte stream.
// Optional macro S1_SYN_ZERO_SKIP_EN replaces syn_done with syn_clean for all-zero syndromes.

module gf2m8_multi (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  logic [7:0] aShift;

  // Shift-and-add multiply, reducing by x^8 = x^4+x^3+x^2+1 (poly 0x11D).
  always_comb begin
    y_o    = 8'h00;
    aShift = a_i;
    for (int k = 0; k < 8; k++) begin
      if (b_i[k]) y_o = y_o ^ aShift;
      aShift = {aShift[6:0], 1'b0} ^ (aShift[7] ? 8'h1D : 8'h00);
    end
  end

endmodule

module s1_syn_calc #(
  parameter int N   = 255,
  parameter int FCR = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din_vld,
  input  logic       din_sop,
  input  logic [7:0] din,
  output logic [7:0] rs_syn0,
  output logic [7:0] rs_syn1,
  output logic [7:0] rs_syn2,
  output logic [7:0] rs_syn3,
  output logic       syn_done,
  output logic       syn_clean
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N - 1);

  function automatic logic [7:0] alphaPow(input int e);
    logic [7:0] p;
    p = 8'h01;
    for (int k = 0; k < (e % 255); k++) p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
    return p;
  endfunction

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] acc_q [4];
  logic [7:0] acc_d [4];
  logic [7:0] prod  [4];
  logic [7:0] syn_q [4];
  logic       syn_done_q;
  logic       allZero;

  for (genvar gi = 0; gi < 4; gi++) begin : g_root
    localparam logic [7:0] ROOT = alphaPow(FCR + gi);
    gf2m8_multi u_mul (
      .a_i (acc_q[gi]),
      .b_i (ROOT),
      .y_o (prod[gi])
    );
    assign acc_d[gi] = prod[gi] ^ din;
  end

  assign allZero = (acc_d[0] == 8'h00) && (acc_d[1] == 8'h00) &&
                   (acc_d[2] == 8'h00) && (acc_d[3] == 8'h00);

`ifdef S1_SYN_ZERO_SKIP_EN
  logic syn_clean_q;
`endif

  // A sop symbol always (re)starts a codeword; the N-th symbol publishes the syndromes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      syn_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= 8'h00;
        syn_q[i] <= 8'h00;
      end
`ifdef S1_SYN_ZERO_SKIP_EN
      syn_clean_q <= 1'b0;
`endif
    end else begin
      syn_done_q <= 1'b0;
`ifdef S1_SYN_ZERO_SKIP_EN
      syn_clean_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (din_vld && din_sop) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= din;
            cnt_q   <= 8'd1;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (din_vld) begin
            if (din_sop) begin
              for (int i = 0; i < 4; i++) acc_q[i] <= din;
              cnt_q <= 8'd1;
            end else if (cnt_q == LAST_CNT) begin
              for (int i = 0; i < 4; i++) syn_q[i] <= acc_d[i];
`ifdef S1_SYN_ZERO_SKIP_EN
              if (allZero) syn_clean_q <= 1'b1;
              else         syn_done_q  <= 1'b1;
`else
              syn_done_q <= 1'b1;
`endif
              cnt_q   <= 8'd0;
              state_q <= IDLE;
            end else begin
              for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rs_syn0  = syn_q[0];
  assign rs_syn1  = syn_q[1];
  assign rs_syn2  = syn_q[2];
  assign rs_syn3  = syn_q[3];
  assign syn_done = syn_done_q;

`ifdef S1_SYN_ZERO_SKIP_EN
  assign syn_clean = syn_clean_q;
`else
  assign syn_clean = 1'b0 & allZero;
`endif

endmodule
